// File: rtl/cpu_pkg.sv
// Shared constants for the 7-step CPU control section: opcodes, ALU ops and step encodings.
// Opcodes JXXX/CLF only take effect when the top is built with CPU_JUMP_IF_EN.
package cpu_pkg;

    localparam int NUM_STEPS = 7;
    localparam int REG_CNT   = 4;

    localparam logic [3:0] OP_LD   = 4'b0000;
    localparam logic [3:0] OP_ST   = 4'b0001;
    localparam logic [3:0] OP_DATA = 4'b0010;
    localparam logic [3:0] OP_JMPR = 4'b0011;
    localparam logic [3:0] OP_JMP  = 4'b0100;
    localparam logic [3:0] OP_JXXX = 4'b0101;
    localparam logic [3:0] OP_CLF  = 4'b0110;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SHR = 3'b001;
    localparam logic [2:0] ALU_SHL = 3'b010;
    localparam logic [2:0] ALU_NOT = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;
    localparam logic [2:0] ALU_CMP = 3'b111;

    // Bit positions of each step inside the one-hot step vector.
    localparam int S1 = 0;
    localparam int S2 = 1;
    localparam int S3 = 2;
    localparam int S4 = 3;
    localparam int S5 = 4;
    localparam int S6 = 5;
    localparam int S7 = 6;

    typedef enum logic [NUM_STEPS-1:0] {
        STEP1 = 7'b0000001,
        STEP2 = 7'b0000010,
        STEP3 = 7'b0000100,
        STEP4 = 7'b0001000,
        STEP5 = 7'b0010000,
        STEP6 = 7'b0100000,
        STEP7 = 7'b1000000
    } step_t;

    function automatic logic [REG_CNT-1:0] reg_onehot(input logic [1:0] idx);
        return REG_CNT'(1) << idx;
    endfunction

endpackage

// File: rtl/cpu_stepper.sv
// 7-position one-hot ring counter that paces the CPU; freezes while hold is high.
module cpu_stepper
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 hold,
    output logic [NUM_STEPS-1:0] step
);

    step_t state_q;
    step_t state_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STEP1;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!hold) begin
            state_d = step_t'({state_q[NUM_STEPS-2:0], state_q[NUM_STEPS-1]});
        end
    end

    assign step = state_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Control decode for the 7-step CPU: turns the current step and IR into bus enable/set strobes.
// Define CPU_JUMP_IF_EN to add the flags input, flags_s output and the JXXX/CLF instructions.
module cpu_step_ctrl
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 hold,
    input  logic [7:0]           ir,
    output logic [NUM_STEPS-1:0] step,
    output logic                 bus1,
    output logic                 iar_e,
    output logic                 iar_s,
    output logic                 mar_s,
    output logic                 ram_e,
    output logic                 ram_s,
    output logic                 ir_s,
    output logic                 tmp_s,
    output logic                 acc_e,
    output logic                 acc_s,
    output logic [REG_CNT-1:0]   reg_e,
    output logic [REG_CNT-1:0]   reg_s,
    output logic [2:0]           alu_op
`ifdef CPU_JUMP_IF_EN
    ,
    input  logic [3:0]           flags,
    output logic                 flags_s
`endif
);

    logic [3:0]         opcode;
    logic [REG_CNT-1:0] ra_sel;
    logic [REG_CNT-1:0] rb_sel;

    assign opcode = ir[7:4];
    assign ra_sel = reg_onehot(ir[3:2]);
    assign rb_sel = reg_onehot(ir[1:0]);

    cpu_stepper u_stepper (
        .clk     (clk),
        .reset_n (reset_n),
        .hold    (hold),
        .step    (step)
    );

    // Steps 1-3 are the shared fetch; from S4 on the opcode picks the micro-sequence.
    always_comb begin
        bus1   = 1'b0;
        iar_e  = 1'b0;
        iar_s  = 1'b0;
        mar_s  = 1'b0;
        ram_e  = 1'b0;
        ram_s  = 1'b0;
        ir_s   = 1'b0;
        tmp_s  = 1'b0;
        acc_e  = 1'b0;
        acc_s  = 1'b0;
        reg_e  = '0;
        reg_s  = '0;
        alu_op = ALU_ADD;
`ifdef CPU_JUMP_IF_EN
        flags_s = 1'b0;
`endif

        case (1'b1)
            step[S1]: begin
                bus1  = 1'b1;
                iar_e = 1'b1;
                mar_s = 1'b1;
                acc_s = 1'b1;
            end
            step[S2]: begin
                ram_e = 1'b1;
                ir_s  = 1'b1;
            end
            step[S3]: begin
                acc_e = 1'b1;
                iar_s = 1'b1;
            end
            step[S4]: begin
                if (ir[7]) begin
                    reg_e = rb_sel;
                    tmp_s = 1'b1;
                end else begin
                    case (opcode)
                        OP_LD, OP_ST: begin
                            reg_e = ra_sel;
                            mar_s = 1'b1;
                        end
                        OP_DATA: begin
                            bus1  = 1'b1;
                            iar_e = 1'b1;
                            mar_s = 1'b1;
                            acc_s = 1'b1;
                        end
                        OP_JMPR: begin
                            reg_e = rb_sel;
                            iar_s = 1'b1;
                        end
                        OP_JMP: begin
                            iar_e = 1'b1;
                            mar_s = 1'b1;
                        end
`ifdef CPU_JUMP_IF_EN
                        OP_JXXX: begin
                            bus1  = 1'b1;
                            iar_e = 1'b1;
                            mar_s = 1'b1;
                            acc_s = 1'b1;
                        end
                        OP_CLF: begin
                            bus1    = 1'b1;
                            flags_s = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            step[S5]: begin
                if (ir[7]) begin
                    reg_e  = ra_sel;
                    alu_op = ir[6:4];
                    acc_s  = 1'b1;
`ifdef CPU_JUMP_IF_EN
                    flags_s = 1'b1;
`endif
                end else begin
                    case (opcode)
                        OP_LD, OP_DATA: begin
                            ram_e = 1'b1;
                            reg_s = rb_sel;
                        end
                        OP_ST: begin
                            reg_e = rb_sel;
                            ram_s = 1'b1;
                        end
                        OP_JMP: begin
                            ram_e = 1'b1;
                            iar_s = 1'b1;
                        end
`ifdef CPU_JUMP_IF_EN
                        OP_JXXX: begin
                            acc_e = 1'b1;
                            iar_s = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            step[S6]: begin
                if (ir[7]) begin
                    acc_e = 1'b1;
                    if (ir[6:4] != ALU_CMP) begin
                        reg_s = rb_sel;
                    end
                end else begin
                    case (opcode)
                        OP_DATA: begin
                            acc_e = 1'b1;
                            iar_s = 1'b1;
                        end
`ifdef CPU_JUMP_IF_EN
                        OP_JXXX: begin
                            ram_e = 1'b1;
                            iar_s = |(ir[3:0] & flags);
                        end
`endif
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase

        // A held CPU must not capture anything, but the bus keeps showing its source.
        if (hold) begin
            iar_s = 1'b0;
            mar_s = 1'b0;
            ram_s = 1'b0;
            ir_s  = 1'b0;
            tmp_s = 1'b0;
            acc_s = 1'b0;
            reg_s = '0;
`ifdef CPU_JUMP_IF_EN
            flags_s = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Self-checking bench for cpu_step_ctrl: directed instructions plus random ir/hold/flags,
// every cycle compared against a step-number/instruction-table reference model.
module tb_cpu_step_ctrl;

`ifdef CPU_JUMP_IF_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    typedef struct packed {
        logic       bus1;
        logic       iar_e;
        logic       iar_s;
        logic       mar_s;
        logic       ram_e;
        logic       ram_s;
        logic       ir_s;
        logic       tmp_s;
        logic       acc_e;
        logic       acc_s;
        logic [3:0] reg_e;
        logic [3:0] reg_s;
        logic [2:0] alu_op;
        logic       flags_s;
    } ctrl_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       hold = 1'b0;
    logic [7:0] ir = 8'h00;
    logic [3:0] flags = 4'b0000;
    logic [6:0] step;
    logic       bus1, iar_e, iar_s, mar_s, ram_e, ram_s, ir_s, tmp_s, acc_e, acc_s;
    logic [3:0] reg_e, reg_s;
    logic [2:0] alu_op;
`ifdef CPU_JUMP_IF_EN
    logic       flags_s;
`endif

    int  tests_run = 0;
    int  tests_failed = 0;
    bit  checking = 1'b0;
    int  model_step = 1;

    cpu_step_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hold    (hold),
        .ir      (ir),
        .step    (step),
        .bus1    (bus1),
        .iar_e   (iar_e),
        .iar_s   (iar_s),
        .mar_s   (mar_s),
        .ram_e   (ram_e),
        .ram_s   (ram_s),
        .ir_s    (ir_s),
        .tmp_s   (tmp_s),
        .acc_e   (acc_e),
        .acc_s   (acc_s),
        .reg_e   (reg_e),
        .reg_s   (reg_s),
        .alu_op  (alu_op)
`ifdef CPU_JUMP_IF_EN
        ,
        .flags   (flags),
        .flags_s (flags_s)
`endif
    );

    always #5 clk = ~clk;

    // Reference stepper: a step number 1..7 that wraps, frozen by hold, forced to 1 by reset.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_step <= 1;
        end else if (!hold) begin
            model_step <= (model_step == 7) ? 1 : model_step + 1;
        end
    end

    // Instruction table: which strobes each instruction class raises in each step number.
    function automatic ctrl_t model_ctrl(input int s, input logic [7:0] i, input logic h,
                                         input logic [3:0] f);
        ctrl_t c;
        int    ra;
        int    rb;
        int    op;
        c  = '0;
        ra = int'(i[3:2]);
        rb = int'(i[1:0]);
        op = int'(i[7:4]);
        if (s == 1) begin
            c.bus1 = 1; c.iar_e = 1; c.mar_s = 1; c.acc_s = 1;
        end else if (s == 2) begin
            c.ram_e = 1; c.ir_s = 1;
        end else if (s == 3) begin
            c.acc_e = 1; c.iar_s = 1;
        end else if (i[7]) begin
            if (s == 4) begin c.reg_e = 4'(1 << rb); c.tmp_s = 1; end
            if (s == 5) begin c.reg_e = 4'(1 << ra); c.alu_op = i[6:4]; c.acc_s = 1; c.flags_s = JUMP_EN; end
            if (s == 6) begin c.acc_e = 1; if (i[6:4] != 3'd7) c.reg_s = 4'(1 << rb); end
        end else if (op == 0 || op == 1) begin
            if (s == 4) begin c.reg_e = 4'(1 << ra); c.mar_s = 1; end
            if (s == 5 && op == 0) begin c.ram_e = 1; c.reg_s = 4'(1 << rb); end
            if (s == 5 && op == 1) begin c.reg_e = 4'(1 << rb); c.ram_s = 1; end
        end else if (op == 2) begin
            if (s == 4) begin c.bus1 = 1; c.iar_e = 1; c.mar_s = 1; c.acc_s = 1; end
            if (s == 5) begin c.ram_e = 1; c.reg_s = 4'(1 << rb); end
            if (s == 6) begin c.acc_e = 1; c.iar_s = 1; end
        end else if (op == 3) begin
            if (s == 4) begin c.reg_e = 4'(1 << rb); c.iar_s = 1; end
        end else if (op == 4) begin
            if (s == 4) begin c.iar_e = 1; c.mar_s = 1; end
            if (s == 5) begin c.ram_e = 1; c.iar_s = 1; end
        end else if (JUMP_EN && op == 5) begin
            if (s == 4) begin c.bus1 = 1; c.iar_e = 1; c.mar_s = 1; c.acc_s = 1; end
            if (s == 5) begin c.acc_e = 1; c.iar_s = 1; end
            if (s == 6) begin c.ram_e = 1; c.iar_s = ((i[3:0] & f) != 4'b0); end
        end else if (JUMP_EN && op == 6) begin
            if (s == 4) begin c.bus1 = 1; c.flags_s = 1; end
        end
        if (h) begin
            c.iar_s = 0; c.mar_s = 0; c.ram_s = 0; c.ir_s = 0;
            c.tmp_s = 0; c.acc_s = 0; c.reg_s = '0; c.flags_s = 0;
        end
        return c;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s (step %0d ir %02h hold %0b): got %0h, expected %0h",
                     tag, model_step, ir, hold, observed, expected);
        end
    endtask

    task automatic compareAll();
        ctrl_t e;
        int    enables;
        e = model_ctrl(model_step, ir, hold, flags);
        checkOutput("step",   32'(step),   32'(1 << (model_step - 1)));
        checkOutput("bus1",   32'(bus1),   32'(e.bus1));
        checkOutput("iar_e",  32'(iar_e),  32'(e.iar_e));
        checkOutput("iar_s",  32'(iar_s),  32'(e.iar_s));
        checkOutput("mar_s",  32'(mar_s),  32'(e.mar_s));
        checkOutput("ram_e",  32'(ram_e),  32'(e.ram_e));
        checkOutput("ram_s",  32'(ram_s),  32'(e.ram_s));
        checkOutput("ir_s",   32'(ir_s),   32'(e.ir_s));
        checkOutput("tmp_s",  32'(tmp_s),  32'(e.tmp_s));
        checkOutput("acc_e",  32'(acc_e),  32'(e.acc_e));
        checkOutput("acc_s",  32'(acc_s),  32'(e.acc_s));
        checkOutput("reg_e",  32'(reg_e),  32'(e.reg_e));
        checkOutput("reg_s",  32'(reg_s),  32'(e.reg_s));
        checkOutput("alu_op", 32'(alu_op), 32'(e.alu_op));
`ifdef CPU_JUMP_IF_EN
        checkOutput("flags_s", 32'(flags_s), 32'(e.flags_s));
`endif
        enables = int'(iar_e) + int'(ram_e) + int'(acc_e) + int'(reg_e != 4'b0);
        checkOutput("one_bus_enable", 32'(enables <= 1), 32'd1);
    endtask

    always @(negedge clk) begin
        if (checking) compareAll();
    end

    task automatic applyStimulus(input logic [7:0] ir_v, input logic hold_v);
        ir   = ir_v;
        hold = hold_v;
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from S1 back to the next S1, optionally holding in step hold_at.
    task automatic runInstr(input logic [7:0] ir_v, input int hold_at, input int hold_len);
        int held;
        bit left;
        bit h;
        held = 0;
        left = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            h = (model_step == hold_at) && (held < hold_len);
            if (h) held++;
            applyStimulus(ir_v, h);
            if (model_step != 1) left = 1'b1;
            else if (left) return;
        end
        checkOutput("instr_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        checking = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        runInstr(8'h00, 0, 0);
        runInstr(8'h86, 0, 0);
        runInstr(8'hF6, 0, 0);
        runInstr(8'h23, 0, 0);
        runInstr(8'h1B, 5, 3);
        runInstr(8'h32, 0, 0);
        runInstr(8'h40, 0, 0);
        runInstr(8'h06, 0, 0);
        runInstr(8'h7F, 2, 2);

        // Abort an ALU instruction in S5 with an asynchronous reset between clock edges.
        for (int cyc = 0; cyc < 10 && model_step != 5; cyc++) applyStimulus(8'h86, 1'b0);
        #2 reset_n = 1'b0;
        #1 checkOutput("async_reset_step", 32'(step), 32'h01);
        @(posedge clk);
        #1 reset_n = 1'b1;
        runInstr(8'h86, 0, 0);

        flags = 4'b0100;
        runInstr(8'h54, 0, 0);
        flags = 4'b0010;
        runInstr(8'h54, 0, 0);
        runInstr(8'h60, 0, 0);

        for (int n = 0; n < 60; n++) begin
            flags = 4'($urandom);
            runInstr(8'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(1, 3)));
        end

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
